hart_mem_arbiter: RTL and testbench

Round-robin request/acknowledge arbiter that shares the single memory-controller port among `N_HARTS` hart/MMU pairs in an RV cluster. Each requester gets an explicit per-transaction handshake, which replaces free-running hart rotation. A per-hart lock keeps the grant on one hart across back-to-back accesses (PTE update, AMO read-modify-write), bounded by a timeout. The block sits between the per-hart cores/MMUs and the memory controller.

---
 rtl/hart_arb_pkg.sv | 26 ++
 rtl/hart_rr_pick.sv | 30 +++
 rtl/hart_mem_arbiter.sv | 140 ++++++++++++++
 tb/tb_hart_mem_arbiter.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hart_arb_pkg.sv
// Shared encodings and helpers for the hart memory-port arbiter.
package hart_arb_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_HOLD  = 2'd3;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic [2:0]  ctrl;
  } mem_cmd_t;

  function automatic int hart_id_w(input int n_harts);
    return $clog2(n_harts);
  endfunction

  function automatic int wrap_add(input int base, input int off, input int n);
    int s;
    s = base + off;
    return (s >= n) ? s - n : s;
  endfunction

endpackage

// File: rtl/hart_rr_pick.sv
// Rotate-priority pick: first eligible hart at or after ptr_i, wrapping.
module hart_rr_pick
  import hart_arb_pkg::*;
#(
  parameter int N_HARTS = 2,
  localparam int IW = hart_id_w(N_HARTS)
) (
  input  logic [N_HARTS-1:0] elig_i,
  input  logic [IW-1:0]      ptr_i,
  output logic               valid_o,
  output logic [IW-1:0]      idx_o
);

  logic [IW-1:0] cand;

  // Walk from the farthest offset down so the nearest eligible hart wins.
  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    cand    = '0;
    for (int i = N_HARTS - 1; i >= 0; i--) begin
      cand = IW'(wrap_add(int'(ptr_i), i, N_HARTS));
      if (elig_i[cand]) begin
        valid_o = 1'b1;
        idx_o   = cand;
      end
    end
  end

endmodule

// File: rtl/hart_mem_arbiter.sv
// Round-robin arbiter sharing one memory-controller port among harts.
// States: IDLE pick | ISSUE strobe controller | WAIT for done | HOLD locked grant.
module hart_mem_arbiter
  import hart_arb_pkg::*;
#(
  parameter int N_HARTS      = 2,
  parameter int LOCK_TIMEOUT = 16,
  localparam int IW = hart_id_w(N_HARTS)
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [N_HARTS-1:0]   w_req,
  input  logic [N_HARTS-1:0]   w_lock,
  input  logic [N_HARTS*32-1:0] w_addr,
  input  logic [N_HARTS*32-1:0] w_wdata,
  input  logic [N_HARTS-1:0]   w_we,
  input  logic [N_HARTS*3-1:0] w_ctrl,
  output logic [N_HARTS-1:0]   w_ack,
  output logic [31:0]          w_rdata,
  output logic [IW-1:0]        w_grant_id,
  output logic                 w_arb_busy,
  output logic                 w_mem_req,
  output logic [31:0]          w_mem_addr,
  output logic [31:0]          w_mem_wdata,
  output logic                 w_mem_we,
  output logic [2:0]           w_mem_ctrl,
  input  logic                 w_mem_done,
  input  logic [31:0]          w_mem_rdata
);

  localparam int CW = $clog2(LOCK_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(LOCK_TIMEOUT - 1);
  localparam logic [IW-1:0] LAST_HART = IW'(N_HARTS - 1);
  localparam logic [N_HARTS-1:0] ACK_ONE = N_HARTS'(1);

  logic [1:0]         state_q, state_d;
  logic [IW-1:0]      ptr_q, ptr_d;
  logic [IW-1:0]      grant_q, grant_d;
  logic [CW-1:0]      lock_cnt_q, lock_cnt_d;
  logic [N_HARTS-1:0] ack_q, ack_d;
  logic [31:0]        rdata_q, rdata_d;
  mem_cmd_t           cmd_q, cmd_d;

  logic [N_HARTS-1:0] elig;
  logic               pick_valid;
  logic [IW-1:0]      pick_idx;
  logic [IW-1:0]      grant_next;
  mem_cmd_t           hart_cmd [N_HARTS];

  // A hart whose ack is high still shows its old request; keep it out.
  assign elig = w_req & ~ack_q;

  for (genvar g = 0; g < N_HARTS; g++) begin : g_cmd
    assign hart_cmd[g] = {w_addr[32*g +: 32], w_wdata[32*g +: 32], w_we[g], w_ctrl[3*g +: 3]};
  end

  hart_rr_pick #(.N_HARTS(N_HARTS)) u_pick (
    .elig_i  (elig),
    .ptr_i   (ptr_q),
    .valid_o (pick_valid),
    .idx_o   (pick_idx)
  );

  assign grant_next = (grant_q == LAST_HART) ? '0 : grant_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    grant_d    = grant_q;
    lock_cnt_d = lock_cnt_q;
    ack_d      = '0;
    rdata_d    = rdata_q;
    cmd_d      = cmd_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          grant_d = pick_idx;
          cmd_d   = hart_cmd[pick_idx];
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        if (w_mem_done) begin
          rdata_d    = w_mem_rdata;
          ack_d      = ACK_ONE << grant_q;
          lock_cnt_d = '0;
          if (w_lock[grant_q]) begin
            state_d = ST_HOLD;
          end else begin
            ptr_d   = grant_next;
            state_d = ST_IDLE;
          end
        end
      end
      ST_HOLD: begin
        lock_cnt_d = lock_cnt_q + 1'b1;
        if (elig[grant_q]) begin
          cmd_d   = hart_cmd[grant_q];
          state_d = ST_ISSUE;
        end else if (!w_lock[grant_q] || lock_cnt_q == CNT_LAST) begin
          ptr_d   = grant_next;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      grant_q    <= '0;
      lock_cnt_q <= '0;
      ack_q      <= '0;
      rdata_q    <= '0;
      cmd_q      <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      grant_q    <= grant_d;
      lock_cnt_q <= lock_cnt_d;
      ack_q      <= ack_d;
      rdata_q    <= rdata_d;
      cmd_q      <= cmd_d;
    end
  end

  assign w_ack       = ack_q;
  assign w_rdata     = rdata_q;
  assign w_grant_id  = grant_q;
  assign w_arb_busy  = (state_q != ST_IDLE);
  assign w_mem_req   = (state_q == ST_ISSUE);
  assign w_mem_addr  = cmd_q.addr;
  assign w_mem_wdata = cmd_q.wdata;
  assign w_mem_we    = cmd_q.we;
  assign w_mem_ctrl  = cmd_q.ctrl;

endmodule

// File: tb/tb_hart_mem_arbiter.sv
// Self-checking bench: table of single transactions plus contention/lock/reset sequences.
module tb_hart_mem_arbiter;

  localparam int N  = 2;
  localparam int LT = 16;

  logic            CLK = 1'b0;
  logic            RST = 1'b1;
  logic [N-1:0]    w_req, w_lock, w_we;
  logic [N*32-1:0] w_addr, w_wdata;
  logic [N*3-1:0]  w_ctrl;
  logic [N-1:0]    w_ack;
  logic [31:0]     w_rdata;
  logic [0:0]      w_grant_id;
  logic            w_arb_busy, w_mem_req, w_mem_we, w_mem_done;
  logic [31:0]     w_mem_addr, w_mem_wdata, w_mem_rdata;
  logic [2:0]      w_mem_ctrl;

  hart_mem_arbiter #(.N_HARTS(N), .LOCK_TIMEOUT(LT)) dut (
    .CLK(CLK), .RST(RST),
    .w_req(w_req), .w_lock(w_lock), .w_addr(w_addr), .w_wdata(w_wdata),
    .w_we(w_we), .w_ctrl(w_ctrl),
    .w_ack(w_ack), .w_rdata(w_rdata), .w_grant_id(w_grant_id), .w_arb_busy(w_arb_busy),
    .w_mem_req(w_mem_req), .w_mem_addr(w_mem_addr), .w_mem_wdata(w_mem_wdata),
    .w_mem_we(w_mem_we), .w_mem_ctrl(w_mem_ctrl),
    .w_mem_done(w_mem_done), .w_mem_rdata(w_mem_rdata)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int          hart;
    logic [31:0] rdata;
  } ack_exp_t;

  typedef struct {
    int          hart;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic [2:0]  ctrl;
    logic        preload;
    logic [31:0] mem_data;
    logic [N-1:0] exp_ack;
    logic [31:0] exp_rdata;
  } vec_t;

  int          exp_grant_q[$];
  ack_exp_t    ack_q[$];
  int          issue_cyc[$];
  int          ack_cyc[$];
  logic [31:0] mem [logic [31:0]];

  int          want[N];
  int          seq[N];
  bit          lock_while[N];
  bit          lock_force[N];
  logic [31:0] cur_addr[N];
  logic [31:0] cur_wdata[N];
  logic        cur_we[N];
  logic [2:0]  cur_ctrl[N];
  int          rise_cyc[N];

  int          mem_lat = 1;
  int          mem_cnt = 0;
  bit          stray   = 1'b0;
  logic [31:0] ret_data = '0;
  int          cyc = 0;
  int          errors = 0;
  int          checks = 0;
  logic [N-1:0] last_ack = '0;
  logic [31:0] last_rdata = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_read(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : ~a;
  endfunction

  function automatic void gen_next(input int g);
    cur_addr[g]  = 32'h1000_0000 + 32'(g) * 32'h100 + 32'(seq[g]) * 32'd4;
    cur_wdata[g] = 32'hA000_0000 ^ cur_addr[g];
    cur_we[g]    = (seq[g] % 2) == 1;
    cur_ctrl[g]  = 3'(seq[g] + g);
  endfunction

  // Hart drivers, memory-controller model and scoreboard, all sampled #1 after posedge.
  initial begin
    int           g_exp;
    ack_exp_t     e;
    logic [N-1:0] oh;
    logic         prev;
    w_req = '0; w_lock = '0; w_addr = '0; w_wdata = '0; w_we = '0; w_ctrl = '0;
    w_mem_done = 1'b0; w_mem_rdata = '0;
    forever begin
      @(posedge CLK); #1;
      cyc++;
      w_mem_done = 1'b0;
      if (RST) begin
        mem_cnt = 0;
        stray   = 1'b0;
      end else begin
        if (mem_cnt > 0) begin
          mem_cnt--;
          if (mem_cnt == 0) begin
            w_mem_done  = 1'b1;
            w_mem_rdata = ret_data;
          end
        end
        if (stray) begin
          w_mem_done  = 1'b1;
          w_mem_rdata = 32'h0BAD_0BAD;
          stray       = 1'b0;
        end
        if (w_mem_req) begin
          issue_cyc.push_back(cyc);
          if (exp_grant_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_issue: grant_id=%0d addr=0x%0h, no issue expected", w_grant_id, w_mem_addr);
          end else begin
            g_exp = exp_grant_q.pop_front();
            chk("grant_id", 64'(w_grant_id), 64'(g_exp));
            chk("mem_addr", 64'(w_mem_addr), 64'(cur_addr[g_exp]));
            chk("mem_wdata", 64'(w_mem_wdata), 64'(cur_wdata[g_exp]));
            chk("mem_we", 64'(w_mem_we), 64'(cur_we[g_exp]));
            chk("mem_ctrl", 64'(w_mem_ctrl), 64'(cur_ctrl[g_exp]));
            e.hart  = g_exp;
            e.rdata = mem_read(cur_addr[g_exp]);
            ack_q.push_back(e);
          end
          ret_data = mem_read(w_mem_addr);
          if (w_mem_we) mem[w_mem_addr] = w_mem_wdata;
          mem_cnt = mem_lat;
        end
        if (w_ack != '0) begin
          ack_cyc.push_back(cyc);
          last_ack   = w_ack;
          last_rdata = w_rdata;
          if (ack_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_ack: ack=0x%0h, no ack expected", w_ack);
          end else begin
            e  = ack_q.pop_front();
            oh = '0;
            oh[e.hart] = 1'b1;
            chk("ack_onehot", 64'(w_ack), 64'(oh));
            chk("ack_rdata", 64'(w_rdata), 64'(e.rdata));
          end
          for (int g = 0; g < N; g++) begin
            if (w_ack[g] && want[g] > 0) begin
              want[g]--;
              seq[g]++;
              gen_next(g);
            end
          end
        end
      end
      for (int g = 0; g < N; g++) begin
        prev     = w_req[g];
        w_req[g] = want[g] > 0;
        if (!prev && w_req[g]) rise_cyc[g] = cyc;
        w_lock[g]           = lock_force[g] | (lock_while[g] && want[g] > 0);
        w_addr[32*g +: 32]  = cur_addr[g];
        w_wdata[32*g +: 32] = cur_wdata[g];
        w_we[g]             = cur_we[g];
        w_ctrl[3*g +: 3]    = cur_ctrl[g];
      end
    end
  end

  task automatic clear_bench();
    for (int g = 0; g < N; g++) begin
      want[g] = 0;
      seq[g] = 0;
      lock_while[g] = 1'b0;
      lock_force[g] = 1'b0;
      gen_next(g);
    end
    exp_grant_q.delete();
    ack_q.delete();
    issue_cyc.delete();
    ack_cyc.delete();
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b1;
    clear_bench();
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
  endtask

  task automatic wait_done(input string name, input int budget);
    int k;
    k = 0;
    while (k < budget && !(want[0] == 0 && want[1] == 0 && exp_grant_q.size() == 0 &&
                           ack_q.size() == 0 && !w_arb_busy)) begin
      @(negedge CLK);
      k++;
    end
    checks++;
    if (k >= budget) begin
      errors++;
      $display("FAIL %s_timeout: pending grants=%0d acks=%0d after %0d cycles, expected 0", name,
               exp_grant_q.size(), ack_q.size(), k);
    end
  endtask

  function automatic int gap(input int a_idx, input int i_idx);
    if (a_idx >= ack_cyc.size() || i_idx >= issue_cyc.size()) return -1;
    return issue_cyc[i_idx] - ack_cyc[a_idx];
  endfunction

  initial begin
    vec_t tbl[5];
    int   k;
    tbl[0] = '{1, 32'h8000_0010, 32'h0000_0000, 1'b0, 3'b010, 1'b1, 32'hDEAD_BEEF, 2'b10, 32'hDEAD_BEEF};
    tbl[1] = '{0, 32'h8000_0020, 32'h1234_5678, 1'b1, 3'b010, 1'b1, 32'hCAFE_F00D, 2'b01, 32'hCAFE_F00D};
    tbl[2] = '{1, 32'h8000_0020, 32'h0000_0000, 1'b0, 3'b100, 1'b0, 32'h0000_0000, 2'b10, 32'h1234_5678};
    tbl[3] = '{0, 32'h0000_0004, 32'h0000_0000, 1'b0, 3'b001, 1'b1, 32'h0000_0000, 2'b01, 32'h0000_0000};
    tbl[4] = '{1, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 1'b1, 3'b111, 1'b1, 32'h55AA_55AA, 2'b10, 32'h55AA_55AA};

    RST = 1'b1;
    clear_bench();
    repeat (3) @(negedge CLK);
    chk("rst_ack", 64'(w_ack), 64'(0));
    chk("rst_rdata", 64'(w_rdata), 64'(0));
    chk("rst_grant_id", 64'(w_grant_id), 64'(0));
    chk("rst_busy", 64'(w_arb_busy), 64'(0));
    chk("rst_mem_req", 64'(w_mem_req), 64'(0));
    chk("rst_mem_cmd", {w_mem_addr, w_mem_wdata}, 64'(0));
    chk("rst_mem_we_ctrl", 64'({w_mem_we, w_mem_ctrl}), 64'(0));
    RST = 1'b0;
    @(negedge CLK);

    for (int i = 0; i < 5; i++) begin
      if (tbl[i].preload) mem[tbl[i].addr] = tbl[i].mem_data;
      cur_addr[tbl[i].hart]  = tbl[i].addr;
      cur_wdata[tbl[i].hart] = tbl[i].wdata;
      cur_we[tbl[i].hart]    = tbl[i].we;
      cur_ctrl[tbl[i].hart]  = tbl[i].ctrl;
      exp_grant_q.push_back(tbl[i].hart);
      want[tbl[i].hart] = 1;
      wait_done($sformatf("vec%0d", i), 50);
      chk($sformatf("vec%0d_ack", i), 64'(last_ack), 64'(tbl[i].exp_ack));
      chk($sformatf("vec%0d_rdata", i), 64'(last_rdata), 64'(tbl[i].exp_rdata));
      chk($sformatf("vec%0d_issue_lat", i),
          64'(issue_cyc.size() > 0 ? issue_cyc[$] - rise_cyc[tbl[i].hart] : -1), 64'(1));
      chk($sformatf("vec%0d_ack_lat", i),
          64'(ack_cyc.size() > 0 ? ack_cyc[$] - rise_cyc[tbl[i].hart] : -1), 64'(3));
    end

    // Stray done while idle must change nothing.
    @(negedge CLK);
    stray = 1'b1;
    repeat (4) begin
      @(negedge CLK);
      chk("stray_ack", 64'(w_ack), 64'(0));
      chk("stray_busy", 64'(w_arb_busy), 64'(0));
      chk("stray_rdata", 64'(w_rdata), 64'(tbl[4].exp_rdata));
    end

    do_reset();
    want[0] = 2;
    want[1] = 2;
    exp_grant_q = '{0, 1, 0, 1};
    wait_done("contention", 100);
    chk("contention_last_grant", 64'(w_grant_id), 64'(1));
    chk("contention_regrant_gap", 64'(gap(0, 1)), 64'(1));

    do_reset();
    want[0] = 3;
    want[1] = 1;
    lock_while[0] = 1'b1;
    exp_grant_q = '{0, 0, 0, 1};
    wait_done("lock", 100);
    chk("lock_b2b_gap1", 64'(gap(0, 1)), 64'(2));
    chk("lock_b2b_gap2", 64'(gap(1, 2)), 64'(2));
    chk("lock_release_gap", 64'(gap(2, 3)), 64'(2));

    do_reset();
    want[0] = 1;
    want[1] = 1;
    lock_force[0] = 1'b1;
    exp_grant_q = '{0, 1};
    wait_done("lock_timeout", 200);
    chk("lock_timeout_gap", 64'(gap(0, 1)), 64'(LT + 1));
    lock_force[0] = 1'b0;

    do_reset();
    want[0] = 1;
    exp_grant_q = '{0};
    wait_done("pre_reset", 50);
    mem_lat = 6;
    want[1] = 1;
    exp_grant_q.push_back(1);
    k = 0;
    while (k < 20 && issue_cyc.size() < 2) begin
      @(negedge CLK);
      k++;
    end
    chk("midwait_issued", 64'(issue_cyc.size()), 64'(2));
    repeat (2) @(negedge CLK);
    chk("midwait_busy", 64'(w_arb_busy), 64'(1));
    RST = 1'b1;
    #1;
    chk("midrst_ack", 64'(w_ack), 64'(0));
    chk("midrst_rdata", 64'(w_rdata), 64'(0));
    chk("midrst_grant_id", 64'(w_grant_id), 64'(0));
    chk("midrst_busy", 64'(w_arb_busy), 64'(0));
    chk("midrst_mem_req", 64'(w_mem_req), 64'(0));
    chk("midrst_mem_cmd", {w_mem_addr, w_mem_wdata}, 64'(0));
    chk("midrst_mem_we_ctrl", 64'({w_mem_we, w_mem_ctrl}), 64'(0));
    clear_bench();
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    mem_lat = 1;
    @(negedge CLK);
    want[0] = 1;
    want[1] = 1;
    exp_grant_q = '{0, 1};
    wait_done("post_reset", 50);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d of %0d checks", errors, checks);
    $fatal(1);
  end

endmodule
